// File: rtl/io_timer.sv
// io_timer: memory-mapped 16-bit timer/compare peripheral on the CPU IO bus.
//
// Decodes BASE_ADDR..BASE_ADDR+7. Register map (byte offsets):
//   0 CTRL      [0] EN, [1] IRQ_EN, [2] AUTO_RELOAD, [3] PWM_EN (PWM build only)
//   1 STATUS    [0] MATCH, [1] OVF (write 1 to clear)
//   2/3 CNT_L/CNT_H   low-byte read snapshots the high byte; CNT_H write commits
//   4/5 CMP_L/CMP_H   CMP_H write commits {CMP_H, CMP_L}
//   6 PRESCALE  tick every PRESCALE+1 enabled cycles
//   7 reserved  reads 0, writes ignored
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   io_addr   bus address
//   io_wdata  write data
//   io_we     write strobe (one cycle per write)
//   io_re     read strobe (one cycle per read)
//   io_rdata  registered read data, 1-cycle latency, [15:8] always 0;
//             0 after an unselected read so responders can be OR-ed
//   irq       level interrupt: IRQ_EN & (MATCH | OVF)
//   pwm_out   (only with IO_TIMER_PWM_EN) registered PWM_EN & EN & (cnt < cmp)
//
// Optional feature macro: IO_TIMER_PWM_EN.

module io_timer #(
    parameter logic [15:0] BASE_ADDR      = 16'h1010,
    parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] io_addr,
    input  logic [7:0]  io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [15:0] io_rdata,
    output logic        irq
`ifdef IO_TIMER_PWM_EN
    ,
    output logic        pwm_out
`endif
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_CNT_L    = 3'd2;
    localparam logic [2:0] OFF_CNT_H    = 3'd3;
    localparam logic [2:0] OFF_CMP_L    = 3'd4;
    localparam logic [2:0] OFF_CMP_H    = 3'd5;
    localparam logic [2:0] OFF_PRESCALE = 3'd6;

    logic        sel;
    logic [2:0]  off;
    logic        wr;
    logic        rd;

    logic        en;
    logic        irq_en;
    logic        auto_reload;
`ifdef IO_TIMER_PWM_EN
    logic        pwm_en;
`endif
    logic        match;
    logic        ovf;
    logic [15:0] cnt;
    logic [15:0] cmp;
    logic [7:0]  prescale;
    logic [7:0]  pcnt;
    logic [7:0]  wbuf;
    logic [7:0]  cnt_hi_snap;

    logic        tick;
    logic        cnt_commit;
    logic        cnt_at_cmp;
    logic        cnt_at_max;
    logic        match_set;
    logic        ovf_set;
    logic        match_clr;
    logic        ovf_clr;
    logic [7:0]  rd_mux;

    always_comb begin
        sel = (io_addr[15:3] == BASE_ADDR[15:3]);
        off = io_addr[2:0];
        wr  = io_we & sel;
        rd  = io_re & sel;
    end

    // A CNT_H commit in the same cycle as a tick takes priority and
    // suppresses that tick's flag updates.
    always_comb begin
        tick       = en && (pcnt == prescale);
        cnt_commit = wr && (off == OFF_CNT_H);
        cnt_at_cmp = (cnt == cmp);
        cnt_at_max = (cnt == 16'hFFFF);
        match_set  = tick && !cnt_commit && cnt_at_cmp;
        ovf_set    = tick && !cnt_commit && cnt_at_max;
        match_clr  = wr && (off == OFF_STATUS) && io_wdata[0];
        ovf_clr    = wr && (off == OFF_STATUS) && io_wdata[1];
    end

    // Read mux uses current (pre-write) register values, so a simultaneous
    // read and write returns the old contents.
    always_comb begin
        rd_mux = '0;
        case (off)
`ifdef IO_TIMER_PWM_EN
            OFF_CTRL:     rd_mux = {4'b0000, pwm_en, auto_reload, irq_en, en};
`else
            OFF_CTRL:     rd_mux = {5'b00000, auto_reload, irq_en, en};
`endif
            OFF_STATUS:   rd_mux = {6'b000000, ovf, match};
            OFF_CNT_L:    rd_mux = cnt[7:0];
            OFF_CNT_H:    rd_mux = cnt_hi_snap;
            OFF_CMP_L:    rd_mux = cmp[7:0];
            OFF_CMP_H:    rd_mux = cmp[15:8];
            OFF_PRESCALE: rd_mux = prescale;
            default:      rd_mux = '0;
        endcase
    end

    // Bus-facing registers: read data, snapshot, control, compare, prescale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata    <= '0;
            cnt_hi_snap <= '0;
            wbuf        <= '0;
            en          <= 1'b0;
            irq_en      <= 1'b0;
            auto_reload <= 1'b0;
`ifdef IO_TIMER_PWM_EN
            pwm_en      <= 1'b0;
`endif
            cmp         <= '0;
            prescale    <= RESET_PRESCALE;
        end else begin
            if (io_re) begin
                io_rdata <= sel ? {8'h00, rd_mux} : '0;
            end
            if (rd && (off == OFF_CNT_L)) begin
                cnt_hi_snap <= cnt[15:8];
            end
            if (wr) begin
                case (off)
                    OFF_CTRL: begin
                        en          <= io_wdata[0];
                        irq_en      <= io_wdata[1];
                        auto_reload <= io_wdata[2];
`ifdef IO_TIMER_PWM_EN
                        pwm_en      <= io_wdata[3];
`endif
                    end
                    OFF_CNT_L,
                    OFF_CMP_L:    wbuf     <= io_wdata;
                    OFF_CMP_H:    cmp      <= {io_wdata, wbuf};
                    OFF_PRESCALE: prescale <= io_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Prescaler, counter and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            cnt   <= '0;
            match <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (!en || cnt_commit || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 8'd1;
            end

            // Overflow and non-reload match both reduce to cnt+1 (16-bit wrap).
            if (cnt_commit) begin
                cnt <= {io_wdata, wbuf};
            end else if (tick) begin
                if (cnt_at_cmp && auto_reload) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end

            // Hardware set wins over a same-cycle software clear.
            match <= match_set | (match & ~match_clr);
            ovf   <= ovf_set   | (ovf   & ~ovf_clr);
        end
    end

`ifdef IO_TIMER_PWM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= pwm_en & en & (cnt < cmp);
        end
    end
`endif

    assign irq = irq_en & (match | ovf);

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer. Expected values come from a tick-count
// model: with EN set at edge e0 and prescale P, edge x has seen
// (x-e0)/(P+1) ticks, from which counter value and flags follow arithmetically.

module tb_io_timer;

    localparam logic [15:0] BASE = 16'h1010;
`ifdef IO_TIMER_PWM_EN
    localparam logic [7:0] CTRL_MASK = 8'h0F;
`else
    localparam logic [7:0] CTRL_MASK = 8'h07;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] io_addr = '0;
    logic [7:0]  io_wdata = '0;
    logic        io_we = 1'b0;
    logic        io_re = 1'b0;
    logic [15:0] io_rdata;
    logic        irq;
`ifdef IO_TIMER_PWM_EN
    logic        pwm_out;
`endif

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    io_timer #(
        .BASE_ADDR(16'h1010),
        .RESET_PRESCALE(8'h5A)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_addr(io_addr),
        .io_wdata(io_wdata),
        .io_we(io_we),
        .io_re(io_re),
        .io_rdata(io_rdata),
        .irq(irq)
`ifdef IO_TIMER_PWM_EN
        ,
        .pwm_out(pwm_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Number of ticks that have happened up to and including edge x.
    function automatic int ticks(input int e0, input int x, input int p);
        return (x > e0) ? (x - e0) / (p + 1) : 0;
    endfunction

    // All bus tasks start and end on a falling edge.
    task automatic bus_write_raw(input logic [15:0] a, input logic [7:0] d);
        io_addr = a; io_wdata = d; io_we = 1'b1;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] o, input logic [7:0] d);
        bus_write_raw(BASE + 16'(o), d);
    endtask

    task automatic bus_read_raw(input logic [15:0] a, output logic [15:0] d);
        io_addr = a; io_re = 1'b1;
        @(negedge clk);
        io_re = 1'b0;
        d = io_rdata;
    endtask

    task automatic bus_read(input logic [2:0] o, output logic [15:0] d);
        bus_read_raw(BASE + 16'(o), d);
    endtask

    task automatic test_reset;
        logic [15:0] d;
        logic [15:0] exp;
        checks++; if (io_rdata !== 16'h0000) $display("FAIL por_rdata got=%h exp=0000", io_rdata); else passes++;
        checks++; if (irq !== 1'b0) $display("FAIL por_irq got=%b exp=0", irq); else passes++;
        for (int unsigned i = 0; i < 8; i++) begin
            bus_read(3'(i), d);
            exp = (i == 6) ? 16'h005A : 16'h0000;
            checks++; if (d !== exp) $display("FAIL por_reg%0d got=%h exp=%h", i, d, exp); else passes++;
        end
        // Run with a pending match so irq and read data are non-zero.
        bus_write(3'd6, 8'h00);
        bus_write(3'd0, 8'h03);
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b1) $display("FAIL pre_rst_irq got=%b exp=1", irq); else passes++;
        bus_read(3'd1, d);
        checks++; if (d !== 16'h0001) $display("FAIL pre_rst_status got=%h exp=0001", d); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (io_rdata !== 16'h0000) $display("FAIL async_rst_rdata got=%h exp=0000", io_rdata); else passes++;
        checks++; if (irq !== 1'b0) $display("FAIL async_rst_irq got=%b exp=0", irq); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            bus_read(3'(i), d);
            exp = (i == 6) ? 16'h005A : 16'h0000;
            checks++; if (d !== exp) $display("FAIL rst_reg%0d got=%h exp=%h", i, d, exp); else passes++;
        end
        checks++; if (irq !== 1'b0) $display("FAIL rst_irq_after got=%b exp=0", irq); else passes++;
    endtask

    task automatic test_prescale;
        logic [15:0] lo, hi, st, c0, exp_cnt, exp_st;
        int p, n, e0, r, s, k;
        logic ien, exp_irq;
        for (int unsigned it = 0; it < 8; it++) begin
            p   = (it == 0) ? 3 : int'($urandom_range(0, 7));
            n   = (it == 0) ? 40 : int'($urandom_range(8, 60));
            c0  = (it % 2 == 1) ? 16'hFFFF - 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 16'hEFFF));
            ien = 1'($urandom_range(0, 1));
            bus_write(3'd0, 8'h00);
            bus_write(3'd1, 8'h03);
            bus_write(3'd4, 8'hFF);
            bus_write(3'd5, 8'hFF);
            bus_write(3'd6, 8'(p));
            bus_write(3'd2, c0[7:0]);
            bus_write(3'd3, c0[15:8]);
            bus_write(3'd0, {6'b0, ien, 1'b1});
            e0 = cyc;
            repeat (n) @(negedge clk);
            bus_read(3'd2, lo);
            r = cyc;
            bus_read(3'd3, hi);
            k = ticks(e0, r - 1, p);
            exp_cnt = 16'(int'(c0) + k);
            checks++;
            if ({hi, lo} !== {8'h00, exp_cnt[15:8], 8'h00, exp_cnt[7:0]})
                $display("FAIL prescale_cnt p=%0d n=%0d got=%h%h exp=%h", p, n, hi[7:0], lo[7:0], exp_cnt);
            else passes++;
            bus_read(3'd1, st);
            s = cyc;
            // cmp=FFFF: wrapping from FFFF sets MATCH and OVF together.
            exp_st = (int'(c0) + ticks(e0, s - 1, p) > 65535) ? 16'h0003 : 16'h0000;
            checks++; if (st !== exp_st) $display("FAIL prescale_status got=%h exp=%h", st, exp_st); else passes++;
            exp_irq = ien && (int'(c0) + ticks(e0, s, p) > 65535);
            checks++; if (irq !== exp_irq) $display("FAIL prescale_irq got=%b exp=%b", irq, exp_irq); else passes++;
        end
    endtask

    task automatic test_match_reload;
        logic [15:0] d;
        int c, p, n, e0, r, w0, k;
        logic exp_irq, exp_match;
        for (int unsigned it = 0; it < 6; it++) begin
            c = (it == 0) ? 5 : int'($urandom_range(1, 12));
            p = (it == 0) ? 0 : int'($urandom_range(0, 2));
            n = int'($urandom_range(5, 70));
            bus_write(3'd0, 8'h00);
            bus_write(3'd1, 8'h03);
            bus_write(3'd4, 8'(c));
            bus_write(3'd5, 8'h00);
            bus_write(3'd6, 8'(p));
            bus_write(3'd2, 8'h00);
            bus_write(3'd3, 8'h00);
            bus_write(3'd0, 8'h07);
            e0 = cyc;
            repeat (n) @(negedge clk);
            bus_read(3'd2, d);
            r = cyc;
            k = ticks(e0, r - 1, p) % (c + 1);
            checks++; if (d !== 16'(k)) $display("FAIL reload_cnt c=%0d p=%0d got=%h exp=%h", c, p, d, 16'(k)); else passes++;
            exp_irq = ticks(e0, r, p) >= c + 1;
            checks++; if (irq !== exp_irq) $display("FAIL reload_irq got=%b exp=%b", irq, exp_irq); else passes++;
            bus_write(3'd0, 8'h06);
            w0 = cyc;
            exp_match = ticks(e0, w0, p) >= c + 1;
            bus_read(3'd1, d);
            checks++; if (d !== {15'b0, exp_match}) $display("FAIL reload_status got=%h exp=%h", d, {15'b0, exp_match}); else passes++;
            bus_write(3'd1, 8'h01);
            checks++; if (irq !== 1'b0) $display("FAIL w1c_irq got=%b exp=0", irq); else passes++;
        end
    endtask

    task automatic test_clear_vs_match;
        logic [15:0] d;
        int c;
        c = int'($urandom_range(2, 10));
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h03);
        bus_write(3'd4, 8'(c));
        bus_write(3'd5, 8'h00);
        bus_write(3'd6, 8'h00);
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h00);
        bus_write(3'd0, 8'h07);
        // Edge e0+c+1 is the first tick with cnt==cmp; land the clear there.
        repeat (c) @(negedge clk);
        bus_write(3'd1, 8'h01);
        checks++; if (irq !== 1'b1) $display("FAIL clr_vs_match_irq got=%b exp=1", irq); else passes++;
        bus_read(3'd1, d);
        checks++; if (d[0] !== 1'b1) $display("FAIL clr_vs_match_flag got=%b exp=1", d[0]); else passes++;
    endtask

    task automatic test_overflow;
        logic [15:0] d;
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h03);
        bus_write(3'd6, 8'h00);
        bus_write(3'd4, 8'h34);
        bus_write(3'd5, 8'h12);
        bus_write(3'd2, 8'hFE);
        bus_write(3'd3, 8'hFF);
        bus_write(3'd0, 8'h03);
        @(negedge clk);
        checks++; if (irq !== 1'b0) $display("FAIL ovf_irq_early got=%b exp=0", irq); else passes++;
        bus_write(3'd0, 8'h02);
        checks++; if (irq !== 1'b1) $display("FAIL ovf_irq got=%b exp=1", irq); else passes++;
        bus_read(3'd2, d);
        checks++; if (d !== 16'h0000) $display("FAIL ovf_cnt_l got=%h exp=0000", d); else passes++;
        bus_read(3'd3, d);
        checks++; if (d !== 16'h0000) $display("FAIL ovf_cnt_h got=%h exp=0000", d); else passes++;
        bus_read(3'd1, d);
        checks++; if (d !== 16'h0002) $display("FAIL ovf_status got=%h exp=0002", d); else passes++;
    endtask

    task automatic test_atomic_read;
        logic [15:0] d;
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h03);
        bus_write(3'd6, 8'h01);
        bus_write(3'd4, 8'hFF);
        bus_write(3'd5, 8'hFF);
        bus_write(3'd2, 8'hFF);
        bus_write(3'd3, 8'h01);
        bus_write(3'd0, 8'h01);
        bus_read(3'd2, d);
        checks++; if (d !== 16'h00FF) $display("FAIL atomic_lo got=%h exp=00FF", d); else passes++;
        @(negedge clk);
        bus_read(3'd3, d);
        checks++; if (d !== 16'h0001) $display("FAIL atomic_hi got=%h exp=0001", d); else passes++;
        bus_read(3'd2, d);
        checks++; if (d !== 16'h0000) $display("FAIL atomic_lo2 got=%h exp=0000", d); else passes++;
        bus_read(3'd3, d);
        checks++; if (d !== 16'h0002) $display("FAIL atomic_hi2 got=%h exp=0002", d); else passes++;
    endtask

    task automatic test_commit_vs_tick;
        logic [15:0] d;
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h03);
        bus_write(3'd6, 8'h00);
        bus_write(3'd4, 8'h10);
        bus_write(3'd5, 8'h00);
        bus_write(3'd2, 8'h0C);
        bus_write(3'd3, 8'h00);
        bus_write(3'd0, 8'h01);
        bus_write(3'd2, 8'h34);
        // Commit lands on the edge where the running count equals cmp (0x10).
        repeat (3) @(negedge clk);
        bus_write(3'd3, 8'h12);
        bus_read(3'd2, d);
        checks++; if (d !== 16'h0034) $display("FAIL commit_lo got=%h exp=0034", d); else passes++;
        bus_read(3'd3, d);
        checks++; if (d !== 16'h0012) $display("FAIL commit_hi got=%h exp=0012", d); else passes++;
        bus_read(3'd1, d);
        checks++; if (d !== 16'h0000) $display("FAIL commit_no_match got=%h exp=0000", d); else passes++;
    endtask

    task automatic test_decode;
        logic [15:0] d;
        logic [15:0] exp_ctrl;
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h03);
        bus_write(3'd6, 8'hA5);
        bus_read(3'd6, d);
        checks++; if (d !== 16'h00A5) $display("FAIL dec_prescale got=%h exp=00A5", d); else passes++;
        bus_read_raw(BASE + 16'd8, d);
        checks++; if (d !== 16'h0000) $display("FAIL dec_above got=%h exp=0000", d); else passes++;
        bus_read(3'd6, d);
        bus_read_raw(BASE - 16'd1, d);
        checks++; if (d !== 16'h0000) $display("FAIL dec_below got=%h exp=0000", d); else passes++;
        bus_write_raw(BASE + 16'd8, 8'hFF);
        bus_write_raw(16'h0016, 8'h00);
        bus_write(3'd7, 8'hFF);
        bus_read(3'd7, d);
        checks++; if (d !== 16'h0000) $display("FAIL dec_reserved got=%h exp=0000", d); else passes++;
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0000) $display("FAIL dec_ctrl_kept got=%h exp=0000", d); else passes++;
        bus_read(3'd6, d);
        checks++; if (d !== 16'h00A5) $display("FAIL dec_prescale_kept got=%h exp=00A5", d); else passes++;
        // Read latency: data changes only after the strobed edge.
        bus_write(3'd0, 8'hFE);
        exp_ctrl = {8'h00, 8'hFE & CTRL_MASK};
        bus_read(3'd6, d);
        io_addr = BASE; io_re = 1'b1;
        checks++; if (io_rdata !== 16'h00A5) $display("FAIL lat_before got=%h exp=00A5", io_rdata); else passes++;
        @(negedge clk);
        io_re = 1'b0;
        checks++; if (io_rdata !== exp_ctrl) $display("FAIL lat_ctrl got=%h exp=%h", io_rdata, exp_ctrl); else passes++;
        @(negedge clk);
        checks++; if (io_rdata !== exp_ctrl) $display("FAIL lat_hold got=%h exp=%h", io_rdata, exp_ctrl); else passes++;
        // Simultaneous read and write: read returns pre-write contents.
        io_addr = BASE; io_wdata = 8'h00; io_we = 1'b1; io_re = 1'b1;
        @(negedge clk);
        io_we = 1'b0; io_re = 1'b0;
        checks++; if (io_rdata !== exp_ctrl) $display("FAIL rw_old got=%h exp=%h", io_rdata, exp_ctrl); else passes++;
        bus_read(3'd0, d);
        checks++; if (d !== 16'h0000) $display("FAIL rw_new got=%h exp=0000", d); else passes++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_prescale;
        test_match_reload;
        test_clear_vs_match;
        test_overflow;
        test_atomic_read;
        test_commit_vs_tick;
        test_decode;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
